// File: rtl/fifo_flow.sv
// Synchronous first-word-fall-through FIFO with flush, occupancy flags and high-water mark.
// Define FIFO_FLOW_BYPASS_EN to let a word pass straight through an empty FIFO in the same cycle.
module fifo_flow #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOGDEPTH   = 3,
    parameter int unsigned AFULL_LVL  = (2 ** LOGDEPTH) - 2,
    parameter int unsigned AEMPTY_LVL = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                enq_val,
    input  logic [WIDTH-1:0]    enq_data,
    output logic                enq_rdy,
    output logic                deq_val,
    output logic [WIDTH-1:0]    deq_data,
    input  logic                deq_rdy,
    output logic [LOGDEPTH:0]   count,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [LOGDEPTH:0]   high_water
);

    localparam int unsigned        DEPTH    = 2 ** LOGDEPTH;
    localparam logic [LOGDEPTH:0]  DEPTH_C  = (LOGDEPTH + 1)'(DEPTH);
    localparam logic [LOGDEPTH:0]  AFULL_C  = (LOGDEPTH + 1)'(AFULL_LVL);
    localparam logic [LOGDEPTH:0]  AEMPTY_C = (LOGDEPTH + 1)'(AEMPTY_LVL);
    localparam logic [LOGDEPTH:0]  CNT_ONE  = (LOGDEPTH + 1)'(1);
    localparam logic [LOGDEPTH-1:0] PTR_ONE = LOGDEPTH'(1);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [LOGDEPTH-1:0] r_wr_ptr;
    logic [LOGDEPTH-1:0] r_rd_ptr;
    logic [LOGDEPTH:0]   r_count;
    logic [LOGDEPTH:0]   r_high_water;

    logic                w_enq_rdy;
    logic                w_stored_val;
    logic                w_store;
    logic                w_pop;
    logic [LOGDEPTH:0]   w_count_next;

    // Full blocks writes even if a dequeue fires in the same cycle.
    assign w_enq_rdy    = (r_count != DEPTH_C) & ~flush;
    assign w_stored_val = (r_count != '0) & ~flush;

`ifdef FIFO_FLOW_BYPASS_EN
    logic w_bypass;

    assign w_bypass = (r_count == '0) & enq_val & ~flush;
    assign deq_val  = w_stored_val | w_bypass;
    assign deq_data = w_bypass ? enq_data : r_mem[r_rd_ptr];
    // A bypassed word consumed this cycle never touches storage.
    assign w_store  = enq_val & w_enq_rdy & ~(w_bypass & deq_rdy);
    assign w_pop    = w_stored_val & deq_rdy;
`else
    assign deq_val  = w_stored_val;
    assign deq_data = r_mem[r_rd_ptr];
    assign w_store  = enq_val & w_enq_rdy;
    assign w_pop    = w_stored_val & deq_rdy;
`endif

    always_comb begin
        w_count_next = r_count;
        if (w_store && !w_pop) begin
            w_count_next = r_count + CNT_ONE;
        end else if (w_pop && !w_store) begin
            w_count_next = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_high_water <= '0;
        end else if (flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_high_water <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_next;
            if (w_count_next > r_high_water) begin
                r_high_water <= w_count_next;
            end
        end
    end

    // Storage is deliberately left uncleared by reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= enq_data;
        end
    end

    assign enq_rdy      = w_enq_rdy;
    assign count        = r_count;
    assign high_water   = r_high_water;
    assign almost_full  = (r_count >= AFULL_C);
    assign almost_empty = (r_count <= AEMPTY_C);

endmodule

// File: tb/tb_fifo_flow.sv
// Directed self-checking bench for fifo_flow at default parameters (WIDTH 8, DEPTH 8).
module tb_fifo_flow;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic       enq_val;
    logic [7:0] enq_data;
    logic       enq_rdy;
    logic       deq_val;
    logic [7:0] deq_data;
    logic       deq_rdy;
    logic [3:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] high_water;

    int checks;
    int failures;

    fifo_flow dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .enq_val      (enq_val),
        .enq_data     (enq_data),
        .enq_rdy      (enq_rdy),
        .deq_val      (deq_val),
        .deq_data     (deq_data),
        .deq_rdy      (deq_rdy),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .high_water   (high_water)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1-2 time units after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        flush    = 1'b0;
        enq_val  = 1'b0;
        enq_data = 8'h00;
        deq_rdy  = 1'b0;
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_enq_rdy", 32'(enq_rdy), 32'd1);
        check("rst_deq_val", 32'(deq_val), 32'd0);
        check("rst_aempty", 32'(almost_empty), 32'd1);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_hw", 32'(high_water), 32'd0);
        #1 reset_n = 1'b1;
        tick();

        // Fill 0xA0..0xA7 with the consumer stalled.
        enq_val  = 1'b1;
        enq_data = 8'hA0;
        #1;
`ifdef FIFO_FLOW_BYPASS_EN
        check("first_enq_deq_val", 32'(deq_val), 32'd1);
`else
        check("first_enq_deq_val", 32'(deq_val), 32'd0);
`endif
        for (int i = 0; i < 8; i++) begin
            enq_data = 8'hA0 + 8'(i);
            tick();
        end
        enq_data = 8'hA8;
        #1;
        check("fill_count", 32'(count), 32'd8);
        check("fill_enq_rdy", 32'(enq_rdy), 32'd0);
        check("fill_afull", 32'(almost_full), 32'd1);
        check("fill_aempty", 32'(almost_empty), 32'd0);
        check("fill_hw", 32'(high_water), 32'd8);
        tick();
        enq_val = 1'b0;
        #1;
        check("ninth_rejected_count", 32'(count), 32'd8);

        // Drain and verify order.
        deq_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("drain_deq_val", 32'(deq_val), 32'd1);
            check("drain_data", 32'(deq_data), 32'(8'hA0 + 8'(i)));
            tick();
        end
        deq_rdy = 1'b0;
        #1;
        check("drained_deq_val", 32'(deq_val), 32'd0);
        check("drained_aempty", 32'(almost_empty), 32'd1);
        check("drained_count", 32'(count), 32'd0);
        check("drained_hw", 32'(high_water), 32'd8);

        // Flush with a concurrent enqueue attempt.
        enq_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            enq_data = 8'hD0 + 8'(i);
            tick();
        end
        #1;
        check("five_count", 32'(count), 32'd5);
        check("five_afull", 32'(almost_full), 32'd0);
        check("five_aempty", 32'(almost_empty), 32'd0);
        flush    = 1'b1;
        enq_data = 8'hEE;
        #1;
        check("flush_enq_rdy", 32'(enq_rdy), 32'd0);
        check("flush_deq_val", 32'(deq_val), 32'd0);
        tick();
        flush   = 1'b0;
        enq_val = 1'b0;
        #1;
        check("post_flush_count", 32'(count), 32'd0);
        check("post_flush_hw", 32'(high_water), 32'd0);
        check("post_flush_deq_val", 32'(deq_val), 32'd0);
        enq_val  = 1'b1;
        enq_data = 8'hF0;
        tick();
        enq_val = 1'b0;
        #1;
        check("post_flush_head", 32'(deq_data), 32'hF0);
        check("post_flush_count1", 32'(count), 32'd1);
        deq_rdy = 1'b1;
        tick();
        deq_rdy = 1'b0;
        #1;
        check("post_flush_empty", 32'(count), 32'd0);

        // Preload 3, then stream 20 words through with both sides active.
        enq_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enq_data = 8'hB0 + 8'(i);
            q.push_back(enq_data);
            tick();
        end
        #1;
        check("wrap_pre_count", 32'(count), 32'd3);
        check("wrap_pre_hw", 32'(high_water), 32'd3);
        deq_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            enq_data = 8'hC0 + 8'(i);
            #1;
            check("wrap_data", 32'(deq_data), 32'(q[0]));
            check("wrap_count", 32'(count), 32'd3);
            void'(q.pop_front());
            q.push_back(enq_data);
            tick();
        end
        enq_val = 1'b0;
        deq_rdy = 1'b0;
        #1;
        check("wrap_post_count", 32'(count), 32'd3);
        check("wrap_post_hw", 32'(high_water), 32'd3);
        check("wrap_post_head", 32'(deq_data), 32'(q[0]));

        // Asynchronous reset pulse between edges with 3 words stored.
        reset_n = 1'b0;
        #1;
        check("async_rst_deq_val", 32'(deq_val), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_hw", 32'(high_water), 32'd0);
        #1 reset_n = 1'b1;
        tick();

        // Enqueue into an empty FIFO with the consumer ready.
        enq_val  = 1'b1;
        enq_data = 8'h5C;
        deq_rdy  = 1'b1;
        #1;
`ifdef FIFO_FLOW_BYPASS_EN
        check("bypass_deq_val", 32'(deq_val), 32'd1);
        check("bypass_data", 32'(deq_data), 32'h5C);
        tick();
        enq_val = 1'b0;
        #1;
        check("bypass_count", 32'(count), 32'd0);
        check("bypass_after_val", 32'(deq_val), 32'd0);
`else
        check("nobypass_deq_val", 32'(deq_val), 32'd0);
        tick();
        enq_val = 1'b0;
        #1;
        check("nobypass_next_val", 32'(deq_val), 32'd1);
        check("nobypass_next_data", 32'(deq_data), 32'h5C);
        check("nobypass_next_count", 32'(count), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
